// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator advancing one pixel per enabled clock.
// Ports: clk, reset (async, active-low), en (pixel tick);
//        x/y counters, hsync/vsync, active video, line_start/frame_start pulses.
// Macro VGA_TIMING_FRAME_COUNT_EN adds frame_cnt[7:0], which steps with each frame_start.
module vga_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          x_wrap, y_wrap;
  logic          hsync_q, vsync_q, active_q, line_start_q, frame_start_q;
  always_comb begin
    x_wrap = x_q == H_LAST;
    y_wrap = y_q == V_LAST;
    x_d    = x_wrap ? '0 : x_q + CW'(1);
    y_d    = x_wrap ? (y_wrap ? '0 : y_q + CW'(1)) : y_q;
  end
  // sync/active are derived from the next counter values so they line up with x/y
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= en & x_wrap;
      frame_start_q <= en & x_wrap & y_wrap;
      if (en) begin
        x_q      <= x_d;
        y_q      <= y_d;
        hsync_q  <= (x_d >= HS_BEG && x_d < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_q  <= (y_d >= VS_BEG && y_d < VS_END) ? SYNC_POL : ~SYNC_POL;
        active_q <= x_d < H_ACT && y_d < V_ACT;
      end
    end
  end
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cnt_q <= '0;
    else if (en & x_wrap & y_wrap) frame_cnt_q <= frame_cnt_q + 8'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for default 640x480 and small SYNC_POL=1 geometries.
module tb_vga_timing;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic [9:0] x0, y0, x1, y1;
  logic hs0, vs0, ac0, ls0, fs0, hs1, vs1, ac1, ls1, fs1;
  logic [7:0] fc0, fc1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  vga_timing u0 (
    .clk(clk), .reset(reset), .en(en), .x(x0), .y(y0), .hsync(hs0), .vsync(vs0),
    .active(ac0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_cnt(fc0)
`endif
  );
  vga_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1), .CW(10)
  ) u1 (
    .clk(clk), .reset(reset), .en(en), .x(x1), .y(y1), .hsync(hs1), .vsync(vs1),
    .active(ac1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_cnt(fc1)
`endif
  );
`ifndef VGA_TIMING_FRAME_COUNT_EN
  assign fc0 = 8'd0;
  assign fc1 = 8'd0;
`endif
  typedef struct {int x; int y; bit ls; bit fs; int fc;} mdl_t;
  typedef struct {logic [32:0] e0; logic [32:0] e1;} exp_t;
  mdl_t m0, m1;
  exp_t q[$];
  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
    end
  endtask
  function automatic mdl_t rst_m();
    mdl_t m;
    m.x = 0; m.y = 0; m.ls = 0; m.fs = 0; m.fc = 0;
    return m;
  endfunction
  function automatic mdl_t adv(input mdl_t m, input bit e, input int ht, input int vt);
    mdl_t n = m;
    n.ls = 0;
    n.fs = 0;
    if (e) begin
      n.x = m.x + 1;
      if (n.x == ht) begin
        n.x = 0;
        n.y = m.y + 1;
        if (n.y == vt) n.y = 0;
        n.ls = 1;
        n.fs = n.y == 0;
        if (n.fs) n.fc = (m.fc + 1) % 256;
      end
    end
    return n;
  endfunction
  function automatic logic [7:0] fcx(input mdl_t m);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    return 8'(m.fc);
`else
    return 8'd0;
`endif
  endfunction
  function automatic logic [32:0] exp0(input mdl_t m);
    logic hs = !(m.x >= 656 && m.x < 752);
    logic vs = !(m.y >= 490 && m.y < 492);
    logic ac = m.x < 640 && m.y < 480;
    return {10'(m.x), 10'(m.y), hs, vs, ac, m.ls, m.fs, fcx(m)};
  endfunction
  function automatic logic [32:0] exp1(input mdl_t m);
    logic hs = m.x >= 5 && m.x < 7;
    logic vs = m.y == 4;
    logic ac = m.x < 4 && m.y < 3;
    return {10'(m.x), 10'(m.y), hs, vs, ac, m.ls, m.fs, fcx(m)};
  endfunction
  function automatic logic [32:0] obs0();
    return {x0, y0, hs0, vs0, ac0, ls0, fs0, fc0};
  endfunction
  function automatic logic [32:0] obs1();
    return {x1, y1, hs1, vs1, ac1, ls1, fs1, fc1};
  endfunction
  task automatic step(input bit e);
    exp_t p;
    en = e;
    m0 = adv(m0, e, 800, 525);
    m1 = adv(m1, e, 8, 6);
    q.push_back('{exp0(m0), exp1(m1)});
    @(posedge clk);
    #1;
    p = q.pop_front();
    chk("d0", obs0(), p.e0);
    chk("d1", obs1(), p.e1);
  endtask
  initial begin
    #1 reset = 1'b0;
    m0 = rst_m();
    m1 = rst_m();
    #1;
    chk("rst0_init", obs0(), exp0(m0));
    chk("rst1_init", obs1(), exp1(m1));
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 300; i++) step(1'b1);
    chk("mid_x", 33'(x0), 33'd300);
    #3 reset = 1'b0;
    en = 1'b1;
    m0 = rst_m();
    m1 = rst_m();
    #1;
    chk("rst0_async", obs0(), exp0(m0));
    chk("rst1_async", obs1(), exp1(m1));
    @(posedge clk);
    #1;
    chk("rst0_hold", obs0(), exp0(m0));
    reset = 1'b1;
    step(1'b1);
    chk("x_after_rst", 33'(x0), 33'd1);
    chk("no_fs_after_rst", 33'(fs0), 33'd0);
    for (int i = 0; i < 1700; i++) step(1'b1);
    for (int i = 0; i < 3300; i++) step(i % 4 == 0);
    for (int i = 0; i < 500; i++) step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 257 * 48 + 20; i++) step(1'b1);
    chk("fc1_model", 33'(fc1), 33'(fcx(m1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
